perceptron_controller: RTL and testbench
========================================

// Module: perceptron_controller
// PURPOSE
//  Sequences one perceptron evaluation: fetches NUM_INPUTS input/weight pairs from external 1-cycle-latency memories,
//  multiply-accumulates them in signed fixed point (sign+q_m+q_n bits, two's complement) on top of a bias, drives the
//  sum into activation_function, samples its activation bit and reports the result with a done pulse.
//  Sits between the layer scheduler (start/done) and the per-neuron weight/input storage and activation_function.
// PARAMETERS
//  sign          1   sign bit count; W = sign+q_m+q_n (33 by default)
//  q_m           16  integer bits
//  q_n           16  fractional bits
//  NUM_INPUTS    4   inputs per neuron, >=1; AW = max(1,$clog2(NUM_INPUTS))
//  ACT_LATENCY   1   cycles from summation_o change to valid activation_i, >=1
// PORTS
//  clk_i           in   1   clock, rising edge
//  rst_i           in   1   asynchronous, active-high reset
//  start_i         in   1   begin evaluation; sampled only in IDLE
//  bias_i          in   W   bias; sampled on accepted start
//  addr_o          out  AW  memory address for x_i/w_i
//  rd_en_o         out  1   memory read strobe
//  x_i             in   W   input value, valid 1 cycle after rd_en_o
//  w_i             in   W   weight value, valid 1 cycle after rd_en_o
//  summation_o     out  W   accumulator, wired to activation_function
//  activation_i    in   1   activation_function output
//  busy_o          out  1   high in any state except IDLE
//  done_o          out  1   1-cycle pulse, result_o valid
//  result_o        out  1   sampled activation, held until next done
//  overflow_o      out  1   saturation occurred in this evaluation (sticky until next start)
// BEHAVIOUR
//  - Reset: state IDLE; addr_o, rd_en_o, summation_o, busy_o, done_o, result_o, overflow_o all 0; idx counter 0.
//  - FSM IDLE -> RUN -> EVAL -> DONE -> IDLE.
//  - IDLE: start_i high at edge E0 -> acc<=bias_i, idx<=0, overflow_o<=0, go RUN. start_i ignored in all other states.
//  - RUN: rd_en_o=1 and addr_o=idx while idx<NUM_INPUTS, idx increments each cycle; rd_en_o=0 after idx reaches
//    NUM_INPUTS. Registered data_valid = rd_en_o delayed 1 cycle; when set, acc <= sat(acc + sat(x_i*w_i >>> q_n)).
//    RUN lasts NUM_INPUTS+1 cycles (last fetch + drain), then EVAL.
//  - Arithmetic: product full 2W-bit signed; arithmetic right shift by q_n (truncate toward -inf);
//    saturate to [-2^(W-1), 2^(W-1)-1]; addition computed W+1 bits, saturated the same way.
//    Any clamp sets overflow_o.
//  - summation_o = acc register at all times (0 after reset; holds last sum in IDLE).
//  - EVAL: wait ACT_LATENCY cycles with acc stable; on last EVAL edge result_o<=activation_i, go DONE.
//  - DONE: done_o=1 for exactly one cycle, busy_o=1; next edge -> IDLE. start_i during DONE is ignored.
//  - Latency: done_o high in cycle after edge E0+NUM_INPUTS+1+ACT_LATENCY; start may be accepted
//    the cycle after done_o.
//  - NUM_INPUTS=1: one fetch, RUN 2 cycles; addr_o stays 0.
//  - rst_i mid-operation: immediate abort to reset values; no done_o, no partial result.
// TESTING
//  1) N=4, x=1.0 (33'h0_0001_0000), w=0.5 (33'h0_0000_8000), bias 0 -> summation_o 33'h0_0002_0000,
//     result_o=1, done_o at E0+6.
//  2) w=-1.0 (33'h1_FFFF_0000), bias 0 -> summation_o -4.0 = 33'h1_FFFC_0000, result_o=0, overflow_o=0.
//  3) x=w=33'h0_7FFF_0000 -> summation_o 33'h0_FFFF_FFFF, overflow_o=1;
//     next start with normal data clears overflow_o.
//  4) start_i held high through RUN/EVAL/DONE -> one done_o per evaluation;
//     new run begins the cycle after done_o; rd_en_o pulses 4 cycles per run.
//  5) rst_i asserted in RUN cycle 2 -> all outputs 0 asynchronously, no done_o;
//     fresh start after release gives test 1 result.
//  6) all x=0, bias 0 -> summation_o 0, result_o equals activation_i stub value at zero;
//     addr_o sequence 0,1,2,3 checked.

Source files
------------

// File: rtl/perceptron_controller.sv
// Perceptron evaluation sequencer: fetches input/weight pairs, accumulates a
// saturating fixed-point dot product on top of a bias, and samples the activation.
module perceptron_controller #(
    parameter int sign        = 1,
    parameter int q_m         = 16,
    parameter int q_n         = 16,
    parameter int NUM_INPUTS  = 4,
    parameter int ACT_LATENCY = 1,
    localparam int W  = sign + q_m + q_n,
    localparam int AW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [W-1:0]  bias_i,
    output logic [AW-1:0] addr_o,
    output logic          rd_en_o,
    input  logic [W-1:0]  x_i,
    input  logic [W-1:0]  w_i,
    output logic [W-1:0]  summation_o,
    input  logic          activation_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          result_o,
    output logic          overflow_o
);

    localparam int CW = $clog2(NUM_INPUTS + 1);
    localparam int EW = (ACT_LATENCY > 1) ? $clog2(ACT_LATENCY) : 1;
    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EVAL,
        DONE
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [CW-1:0]   r_idx;
    logic [EW-1:0]   r_evalCnt;
    logic            r_dataValid;
    logic [W-1:0]    r_acc;
    logic            r_result;
    logic            r_overflow;
    logic            w_evalLast;

    logic signed [2*W-1:0] w_xExt;
    logic signed [2*W-1:0] w_wExt;
    logic signed [2*W-1:0] w_product;
    logic signed [2*W-1:0] w_shifted;
    logic [W:0]            w_prodHi;
    logic                  w_prodClamp;
    logic [W-1:0]          w_prodSat;
    logic [W:0]            w_sumWide;
    logic                  w_sumClamp;
    logic [W-1:0]          w_sumSat;

    // Product fits in 2W bits, so both operands are widened before multiplying.
    assign w_xExt    = {{W{x_i[W-1]}}, x_i};
    assign w_wExt    = {{W{w_i[W-1]}}, w_i};
    assign w_product = w_xExt * w_wExt;
    assign w_shifted = w_product >>> q_n;

    assign w_prodHi    = w_shifted[2*W-1:W-1];
    assign w_prodClamp = !((&w_prodHi) || !(|w_prodHi));
    assign w_prodSat   = w_prodClamp ? (w_shifted[2*W-1] ? SAT_MIN : SAT_MAX)
                                     : w_shifted[W-1:0];

    assign w_sumWide  = {r_acc[W-1], r_acc} + {w_prodSat[W-1], w_prodSat};
    assign w_sumClamp = w_sumWide[W] ^ w_sumWide[W-1];
    assign w_sumSat   = w_sumClamp ? (w_sumWide[W] ? SAT_MIN : SAT_MAX)
                                   : w_sumWide[W-1:0];

    assign w_evalLast = (r_evalCnt == EW'(ACT_LATENCY - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start_i) w_nextState = RUN;
            RUN:     if (r_idx == CW'(NUM_INPUTS)) w_nextState = EVAL;
            EVAL:    if (w_evalLast) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // The address is forced to zero outside active fetches so it never shows the drain index.
    always_comb begin
        rd_en_o = 1'b0;
        addr_o  = '0;
        busy_o  = (r_state != IDLE);
        done_o  = (r_state == DONE);
        if ((r_state == RUN) && (r_idx < CW'(NUM_INPUTS))) begin
            rd_en_o = 1'b1;
            addr_o  = r_idx[AW-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_acc       <= '0;
            r_idx       <= '0;
            r_dataValid <= 1'b0;
            r_evalCnt   <= '0;
            r_result    <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_acc       <= bias_i;
                        r_idx       <= '0;
                        r_dataValid <= 1'b0;
                        r_overflow  <= 1'b0;
                    end
                end
                RUN: begin
                    r_dataValid <= rd_en_o;
                    r_evalCnt   <= '0;
                    if (rd_en_o) begin
                        r_idx <= r_idx + CW'(1);
                    end
                    if (r_dataValid) begin
                        r_acc <= w_sumSat;
                        if (w_prodClamp || w_sumClamp) begin
                            r_overflow <= 1'b1;
                        end
                    end
                end
                EVAL: begin
                    r_evalCnt <= r_evalCnt + EW'(1);
                    if (w_evalLast) begin
                        r_result <= activation_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign summation_o = r_acc;
    assign result_o    = r_result;
    assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_perceptron_controller.sv
// Scoreboard bench for perceptron_controller: directed runs push expected results,
// a monitor pops and compares them whenever done_o pulses.
module tb_perceptron_controller;

    localparam int W = 33;

    typedef struct {
        logic [W-1:0] sum;
        logic         res;
        logic         ovf;
        int           doneCycle;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] bias = '0;
    logic [1:0]   addr;
    logic         rdEn;
    logic [W-1:0] xData = '0;
    logic [W-1:0] wData = '0;
    logic [W-1:0] summation;
    logic         activation;
    logic         busy;
    logic         done;
    logic         result;
    logic         overflow;

    logic [W-1:0] xMem [4];
    logic [W-1:0] wMem [4];
    exp_t         sbQ [$];
    exp_t         mon;
    logic [1:0]   addrLog [$];
    int           rdCount = 0;
    int           cycleCnt = 0;
    int           checks = 0;
    int           errors = 0;
    int           e0;

    perceptron_controller dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .bias_i       (bias),
        .addr_o       (addr),
        .rd_en_o      (rdEn),
        .x_i          (xData),
        .w_i          (wData),
        .summation_o  (summation),
        .activation_i (activation),
        .busy_o       (busy),
        .done_o       (done),
        .result_o     (result),
        .overflow_o   (overflow)
    );

    always #5 clk = ~clk;

    // Step activation: fires for any non-negative sum, including zero.
    assign activation = ~summation[W-1];

    always @(posedge clk) begin
        cycleCnt <= cycleCnt + 1;
        if (rdEn) begin
            xData <= xMem[addr];
            wData <= wMem[addr];
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rdEn) begin
            rdCount++;
            addrLog.push_back(addr);
        end
        if (done) begin
            if (sbQ.size() == 0) begin
                checkOutput("done_without_expectation", 64'(done), 64'(0));
            end else begin
                mon = sbQ.pop_front();
                checkOutput("summation", 64'(summation), 64'(mon.sum));
                checkOutput("result", 64'(result), 64'(mon.res));
                checkOutput("overflow", 64'(overflow), 64'(mon.ovf));
                checkOutput("done_cycle", 64'(cycleCnt), 64'(mon.doneCycle));
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] xv, input logic [W-1:0] wv,
                                 input logic [W-1:0] bv, input logic [W-1:0] expSum,
                                 input logic expRes, input logic expOvf,
                                 input bit hold, output int startEdge);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            xMem[i] = xv;
            wMem[i] = wv;
        end
        bias  = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        startEdge = cycleCnt;
        sbQ.push_back('{expSum, expRes, expOvf, startEdge + 6});
        checkOutput("busy_after_start", 64'(busy), 64'(1));
        checkOutput("overflow_cleared_on_start", 64'(overflow), 64'(0));
        if (!hold) start = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sbQ.size() == 0) break;
            @(negedge clk);
        end
        checkOutput("drain_timeout", 64'(sbQ.size()), 64'(0));
        sbQ.delete();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            xMem[i] = '0;
            wMem[i] = '0;
        end
        repeat (2) @(negedge clk);
        checkOutput("reset_summation", 64'(summation), 64'(0));
        checkOutput("reset_result", 64'(result), 64'(0));
        checkOutput("reset_overflow", 64'(overflow), 64'(0));
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(0));
        checkOutput("reset_rd_en", 64'(rdEn), 64'(0));
        checkOutput("reset_addr", 64'(addr), 64'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] basic: 4 x (1.0 * 0.5)");
        applyStimulus(33'h0_0001_0000, 33'h0_0000_8000, 33'h0, 33'h0_0002_0000, 1'b1, 1'b0, 1'b0, e0);
        waitDrain(30);

        $display("[TB] negative weights");
        applyStimulus(33'h0_0001_0000, 33'h1_FFFF_0000, 33'h0, 33'h1_FFFC_0000, 1'b0, 1'b0, 1'b0, e0);
        waitDrain(30);

        $display("[TB] positive saturation");
        applyStimulus(33'h0_7FFF_0000, 33'h0_7FFF_0000, 33'h0, 33'h0_FFFF_FFFF, 1'b1, 1'b1, 1'b0, e0);
        waitDrain(30);

        $display("[TB] zero inputs, address sequence");
        addrLog.delete();
        applyStimulus(33'h0, 33'h0_0000_8000, 33'h0, 33'h0, 1'b1, 1'b0, 1'b0, e0);
        waitDrain(30);
        checkOutput("addr_count", 64'(addrLog.size()), 64'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < addrLog.size()) checkOutput("addr_sequence", 64'(addrLog[i]), 64'(i));
        end

        $display("[TB] negative bias");
        applyStimulus(33'h0_0001_0000, 33'h0_0000_8000, 33'h1_FFFF_0000, 33'h0_0001_0000, 1'b1, 1'b0, 1'b0, e0);
        waitDrain(30);

        $display("[TB] shift truncates toward minus infinity");
        applyStimulus(33'h1_FFFF_FFFF, 33'h0_0000_8000, 33'h0, 33'h1_FFFF_FFFC, 1'b0, 1'b0, 1'b0, e0);
        waitDrain(30);

        $display("[TB] negative saturation");
        applyStimulus(33'h1_8000_0000, 33'h0_7FFF_0000, 33'h0, 33'h1_0000_0000, 1'b0, 1'b1, 1'b0, e0);
        waitDrain(30);

        $display("[TB] start held high across two runs");
        rdCount = 0;
        applyStimulus(33'h0_0001_0000, 33'h0_0000_8000, 33'h0, 33'h0_0002_0000, 1'b1, 1'b0, 1'b1, e0);
        sbQ.push_back('{33'h0_0002_0000, 1'b1, 1'b0, e0 + 14});
        while (cycleCnt < e0 + 10) @(negedge clk);
        start = 1'b0;
        waitDrain(40);
        checkOutput("rd_en_cycles_two_runs", 64'(rdCount), 64'(8));

        $display("[TB] reset abort in RUN");
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_summation", 64'(summation), 64'(0));
        checkOutput("abort_result", 64'(result), 64'(0));
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_rd_en", 64'(rdEn), 64'(0));
        checkOutput("abort_addr", 64'(addr), 64'(0));
        checkOutput("abort_done", 64'(done), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("result_after_abort", 64'(result), 64'(0));
        applyStimulus(33'h0_0001_0000, 33'h0_0000_8000, 33'h0, 33'h0_0002_0000, 1'b1, 1'b0, 1'b0, e0);
        waitDrain(30);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
